// File: rtl/wic_int_arb.sv
// WIC interrupt arbiter: picks one enabled pending source, presents it to the CPU, and strobes its clear index back to the WIC on acknowledge.
// Define WIC_ARB_RR_EN for round-robin arbitration; without it the lowest index wins.
`timescale 1ns/1ps
module wic_int_arb #(
    parameter int NUM_INT  = 32,
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 255
) (
    input  logic               wic_clk,
    input  logic               pad_cpu_rst,
    input  logic [NUM_INT-1:0] int_pending,
    input  logic [NUM_INT-1:0] ctl_xx_awake_enable,
    input  logic               cpu_int_ack,
    input  logic               arb_err_clr,
    output logic               arb_int_vld,
    output logic [4:0]         arb_int_id,
    output logic               vec_int,
    output logic [4:0]         int_ack_vec,
    output logic               arb_to_err
);

    typedef enum logic [1:0] {IDLE, REQ, CLR, WAIT} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_LIMIT == 0) ? 0 : TO_LIMIT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    state_e          state_q;
    logic            arb_int_vld_q;
    logic [4:0]      arb_int_id_q;
    logic            vec_int_q;
    logic [4:0]      int_ack_vec_q;
    logic            arb_to_err_q;
    logic [TO_W-1:0] cnt_q;

    logic [31:0]     cand;
    logic [4:0]      winner_d;
    logic            to_hit;

    assign cand   = 32'(int_pending & ctl_xx_awake_enable);
    assign to_hit = (TO_LIMIT != 0) && (cnt_q == TO_LAST);

`ifdef WIC_ARB_RR_EN
    logic [4:0] ptr_q;
    logic [4:0] ptr_d;
    logic [5:0] idx;
    logic       found;

    assign ptr_d = (arb_int_id_q == 5'(NUM_INT - 1)) ? 5'd0 : arb_int_id_q + 5'd1;

    // Scan upward from the pointer, wrapping at NUM_INT; the first hit wins.
    always_comb begin
        winner_d = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_INT; k++) begin
            idx = {1'b0, ptr_q} + 6'(k);
            if (idx >= 6'(NUM_INT)) begin
                idx = idx - 6'(NUM_INT);
            end
            if (!found && cand[idx[4:0]]) begin
                found    = 1'b1;
                winner_d = idx[4:0];
            end
        end
    end
`else
    always_comb begin
        winner_d = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner_d = 5'(i);
            end
        end
    end
`endif

    // The timeout set is written after the clear so it wins when both occur together.
    always_ff @(posedge wic_clk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            state_q       <= IDLE;
            arb_int_vld_q <= 1'b0;
            arb_int_id_q  <= '0;
            vec_int_q     <= 1'b0;
            int_ack_vec_q <= '0;
            arb_to_err_q  <= 1'b0;
            cnt_q         <= '0;
`ifdef WIC_ARB_RR_EN
            ptr_q         <= '0;
`endif
        end else begin
            vec_int_q <= 1'b0;
            if (arb_err_clr) begin
                arb_to_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q       <= REQ;
                        arb_int_vld_q <= 1'b1;
                        arb_int_id_q  <= winner_d;
                        cnt_q         <= '0;
                    end
                end
                REQ: begin
                    if (cpu_int_ack) begin
                        state_q       <= CLR;
                        arb_int_vld_q <= 1'b0;
                        vec_int_q     <= 1'b1;
                        int_ack_vec_q <= arb_int_id_q;
`ifdef WIC_ARB_RR_EN
                        ptr_q         <= ptr_d;
`endif
                    end else if (!cand[arb_int_id_q]) begin
                        state_q       <= IDLE;
                        arb_int_vld_q <= 1'b0;
                    end else if (to_hit) begin
                        state_q       <= IDLE;
                        arb_int_vld_q <= 1'b0;
                        arb_to_err_q  <= 1'b1;
`ifdef WIC_ARB_RR_EN
                        ptr_q         <= ptr_d;
`endif
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                CLR: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign arb_int_vld = arb_int_vld_q;
    assign arb_int_id  = arb_int_id_q;
    assign vec_int     = vec_int_q;
    assign int_ack_vec = int_ack_vec_q;
    assign arb_to_err  = arb_to_err_q;

endmodule

// File: tb/tb_wic_int_arb.sv
// Bench for wic_int_arb: directed scenarios with a transaction-level reference model compared every cycle.
`timescale 1ns/1ps
module tb_wic_int_arb;

    localparam int NUM_INT  = 32;
    localparam int TO_LIMIT = 4;
`ifdef WIC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        wic_clk = 1'b0;
    logic        pad_cpu_rst;
    logic [31:0] int_pending;
    logic [31:0] ctl_xx_awake_enable;
    logic        cpu_int_ack;
    logic        arb_err_clr;
    logic        arb_int_vld;
    logic [4:0]  arb_int_id;
    logic        vec_int;
    logic [4:0]  int_ack_vec;
    logic        arb_to_err;

    int checksTotal  = 0;
    int checksPassed = 0;
    bit compareEn    = 1'b0;

    wic_int_arb #(.NUM_INT(NUM_INT), .TO_W(8), .TO_LIMIT(TO_LIMIT)) dut (
        .wic_clk            (wic_clk),
        .pad_cpu_rst        (pad_cpu_rst),
        .int_pending        (int_pending),
        .ctl_xx_awake_enable(ctl_xx_awake_enable),
        .cpu_int_ack        (cpu_int_ack),
        .arb_err_clr        (arb_err_clr),
        .arb_int_vld        (arb_int_vld),
        .arb_int_id         (arb_int_id),
        .vec_int            (vec_int),
        .int_ack_vec        (int_ack_vec),
        .arb_to_err         (arb_to_err)
    );

    always #5 wic_clk = ~wic_clk;

    // Reference model: "presenting" flag, age of the request, and a post-ack gap in cycles.
    logic mVld, mVec, mErr;
    int   mId, mAckVec, mAge, mGap, mPtr;

    function automatic int pick(logic [31:0] c, int start);
        for (int k = 0; k < NUM_INT; k++) begin
            if (c[(start + k) % NUM_INT]) return (start + k) % NUM_INT;
        end
        return 0;
    endfunction

    always @(posedge wic_clk or posedge pad_cpu_rst) begin : model
        logic [31:0] c;
        logic nVld, nVec, nErr, timedOut;
        int nId, nAckVec, nAge, nGap, nPtr;
        if (pad_cpu_rst) begin
            mVld <= 1'b0; mVec <= 1'b0; mErr <= 1'b0;
            mId <= 0; mAckVec <= 0; mAge <= 0; mGap <= 0; mPtr <= 0;
        end else begin
            c = int_pending & ctl_xx_awake_enable;
            nVld = mVld; nVec = 1'b0; nErr = mErr; timedOut = 1'b0;
            nId = mId; nAckVec = mAckVec; nAge = mAge; nGap = mGap; nPtr = mPtr;
            if (mVld) begin
                if (cpu_int_ack) begin
                    nVld = 1'b0; nVec = 1'b1; nAckVec = mId; nGap = 2;
                    nPtr = (mId + 1) % NUM_INT;
                end else if (!c[mId]) begin
                    nVld = 1'b0;
                end else if (mAge + 1 == TO_LIMIT) begin
                    nVld = 1'b0; timedOut = 1'b1;
                    nPtr = (mId + 1) % NUM_INT;
                end else begin
                    nAge = mAge + 1;
                end
            end else if (mGap > 0) begin
                nGap = mGap - 1;
            end else if (c != 0) begin
                nVld = 1'b1; nId = pick(c, RR ? mPtr : 0); nAge = 0;
            end
            if (timedOut) nErr = 1'b1;
            else if (arb_err_clr) nErr = 1'b0;
            mVld <= nVld; mVec <= nVec; mErr <= nErr;
            mId <= nId; mAckVec <= nAckVec; mAge <= nAge; mGap <= nGap; mPtr <= nPtr;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            checksPassed++;
        end
    endtask

    always @(negedge wic_clk) begin
        if (compareEn) begin
            checkOutput("model_vld",    32'(arb_int_vld), 32'(mVld));
            checkOutput("model_vec",    32'(vec_int),     32'(mVec));
            checkOutput("model_err",    32'(arb_to_err),  32'(mErr));
            checkOutput("model_ackvec", 32'(int_ack_vec), 32'(mAckVec));
            if (mVld) checkOutput("model_id", 32'(arb_int_id), 32'(mId));
        end
    end

    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] e, input logic a, input logic c);
        int_pending         = p;
        ctl_xx_awake_enable = e;
        cpu_int_ack         = a;
        arb_err_clr         = c;
        @(posedge wic_clk);
        #2;
    endtask

    task automatic waitForGrant(input logic clr);
        int n = 0;
        while (!arb_int_vld && n < 20) begin
            applyStimulus(int_pending, ctl_xx_awake_enable, 1'b0, clr);
            n++;
        end
        if (!arb_int_vld) checkOutput("grant_wait_expired", 32'(arb_int_vld), 32'd1);
    endtask

    task automatic serviceOne(input int id, input bit clearPend);
        logic [31:0] p;
        waitForGrant(1'b0);
        checkOutput("grant_id", 32'(arb_int_id), 32'(id));
        applyStimulus(int_pending, ctl_xx_awake_enable, 1'b1, 1'b0);
        checkOutput("clr_vec", 32'(vec_int), 32'd1);
        checkOutput("clr_ackvec", 32'(int_ack_vec), 32'(id));
        checkOutput("clr_vld_low", 32'(arb_int_vld), 32'd0);
        p = int_pending;
        if (clearPend) p[id] = 1'b0;
        applyStimulus(p, ctl_xx_awake_enable, 1'b0, 1'b0);
        checkOutput("vec_one_cycle", 32'(vec_int), 32'd0);
    endtask

    initial begin
        int n;
        int order3[3];
        int order4[4];
        logic [31:0] allEn;
        allEn = 32'hFFFF_FFFF;
        if (RR) begin
            order3 = '{5, 19, 0};
            order4 = '{2, 7, 2, 7};
        end else begin
            order3 = '{0, 5, 19};
            order4 = '{2, 2, 2, 2};
        end

        pad_cpu_rst = 1'b1;
        int_pending = '0; ctl_xx_awake_enable = '0; cpu_int_ack = 1'b0; arb_err_clr = 1'b0;
        repeat (2) @(posedge wic_clk);
        #2;
        checkOutput("rst_vld", 32'(arb_int_vld), 32'd0);
        checkOutput("rst_id", 32'(arb_int_id), 32'd0);
        checkOutput("rst_vec", 32'(vec_int), 32'd0);
        checkOutput("rst_err", 32'(arb_to_err), 32'd0);
        pad_cpu_rst = 1'b0;
        compareEn   = 1'b1;
        applyStimulus('0, allEn, 1'b0, 1'b0);

        $display("[TB] single source");
        int_pending = 32'h0000_0008;
        serviceOne(3, 1'b1);

        $display("[TB] three sources");
        int_pending = 32'h0008_0021;
        for (int i = 0; i < 3; i++) serviceOne(order3[i], 1'b1);

        $display("[TB] two sources held pending");
        int_pending = 32'h0000_0084;
        for (int i = 0; i < 4; i++) serviceOne(order4[i], 1'b0);
        applyStimulus('0, allEn, 1'b0, 1'b0);

        $display("[TB] timeout");
        int_pending = 32'h0000_0200;
        waitForGrant(1'b0);
        n = 0;
        while (arb_int_vld && n < 20) begin
            checkOutput("to_no_vec", 32'(vec_int), 32'd0);
            applyStimulus(int_pending, allEn, 1'b0, 1'b0);
            n++;
        end
        checkOutput("to_vld_cycles", 32'(n), 32'd4);
        checkOutput("to_err_set", 32'(arb_to_err), 32'd1);
        applyStimulus('0, allEn, 1'b0, 1'b1);
        checkOutput("to_err_cleared", 32'(arb_to_err), 32'd0);

        $display("[TB] timeout with clear held");
        int_pending = 32'h0000_0200;
        waitForGrant(1'b1);
        n = 0;
        while (arb_int_vld && n < 20) begin
            applyStimulus(int_pending, allEn, 1'b0, 1'b1);
            n++;
        end
        checkOutput("set_wins_err", 32'(arb_to_err), 32'd1);
        applyStimulus('0, allEn, 1'b0, 1'b1);
        checkOutput("set_wins_cleared", 32'(arb_to_err), 32'd0);
        applyStimulus('0, allEn, 1'b0, 1'b0);

        $display("[TB] withdraw");
        int_pending = 32'h0000_0010;
        waitForGrant(1'b0);
        checkOutput("wd_id", 32'(arb_int_id), 32'd4);
        applyStimulus(int_pending, allEn & ~32'h0000_0010, 1'b0, 1'b0);
        checkOutput("wd_vld_low", 32'(arb_int_vld), 32'd0);
        checkOutput("wd_no_vec", 32'(vec_int), 32'd0);
        checkOutput("wd_no_err", 32'(arb_to_err), 32'd0);
        applyStimulus('0, allEn, 1'b0, 1'b0);
        applyStimulus('0, allEn, 1'b0, 1'b0);

        $display("[TB] ack on the timeout cycle, then reset in CLR");
        int_pending = 32'h0000_1000;
        waitForGrant(1'b0);
        repeat (3) applyStimulus(int_pending, allEn, 1'b0, 1'b0);
        applyStimulus(int_pending, allEn, 1'b1, 1'b0);
        checkOutput("coin_vec", 32'(vec_int), 32'd1);
        checkOutput("coin_ackvec", 32'(int_ack_vec), 32'd12);
        checkOutput("coin_no_err", 32'(arb_to_err), 32'd0);
        cpu_int_ack = 1'b0;
        pad_cpu_rst = 1'b1;
        #1;
        checkOutput("arst_vld", 32'(arb_int_vld), 32'd0);
        checkOutput("arst_vec", 32'(vec_int), 32'd0);
        checkOutput("arst_ackvec", 32'(int_ack_vec), 32'd0);
        checkOutput("arst_id", 32'(arb_int_id), 32'd0);
        checkOutput("arst_err", 32'(arb_to_err), 32'd0);
        @(posedge wic_clk);
        #2;
        pad_cpu_rst = 1'b0;
        repeat (3) applyStimulus('0, allEn, 1'b0, 1'b0);

        compareEn = 1'b0;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
